// File: rtl/ecc_pkg.sv
// Shared constants and helper functions for the 11-to-16 SECDED code.
// The data-bit position table and the parity masks are kept here so the
// encoder and the decoder can never disagree on the codeword layout.
package ecc_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;
  localparam int SYN_W  = 4;

  // Codeword index of each data bit, data[0] first.
  localparam logic [3:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Bits covered by Hamming parity p(2^k): every index 1..15 with bit k set,
  // excluding the parity bit's own position.
  localparam logic [CODE_W-1:0] PAR_MASK [SYN_W] = '{
    16'hAAA8, 16'hCCC8, 16'hF0E0, 16'hFE00
  };

  // Build the full codeword: scatter data, fill Hamming parities, then the
  // overall parity in bit 0 so the whole word has even parity.
  function automatic logic [CODE_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    code = 16'h0000;
    for (int i = 0; i < DATA_W; i++) begin
      code[DATA_POS[i]] = data[i];
    end
    for (int k = 0; k < SYN_W; k++) begin
      code[32'd1 << k] = ^(code & PAR_MASK[k]);
    end
    code[0] = ^code[CODE_W-1:1];
    return code;
  endfunction

  // XOR of the indices of all set bits among code[15:1].
  function automatic logic [SYN_W-1:0] ecc_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] syn;
    syn = 4'd0;
    for (int i = 1; i < CODE_W; i++) begin
      syn = syn ^ (code[i] ? 4'(i) : 4'd0);
    end
    return syn;
  endfunction

  // Gather the data bits back out of a codeword.
  function automatic logic [DATA_W-1:0] ecc_extract(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    data = 11'h000;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = code[DATA_POS[i]];
    end
    return data;
  endfunction

endpackage

// File: rtl/ecc_11to16_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module ecc_11to16_cnt
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count flagged cycles, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ecc_11to16_core.sv
// SECDED 11-to-16 encoder/decoder with correctable/uncorrectable error
// statistics. Encode and decode paths are combinational and reset-free;
// only the two event counters are clocked.
module ecc_11to16_core
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] enc_in,
  output logic [CODE_W-1:0] enc_out,
  input  logic [CODE_W-1:0] dec_in,
  output logic [DATA_W-1:0] dec_out,
  output logic              err_correct,
  output logic              err_uncorrect,
  output logic [SYN_W-1:0]  err_location,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic [CODE_W-1:0] enc_code_s;
  logic [SYN_W-1:0]  syn_s;
  logic              par_s;
  logic [CODE_W-1:0] fixed_s;
  logic              corr_s;
  logic              uncorr_s;
  logic [SYN_W-1:0]  loc_s;
  logic [1:0]        rst_sync_r;
  logic              cnt_rst_n_s;

  // Encoder: data word to full SECDED codeword.
  always_comb begin
    enc_code_s = ecc_encode(enc_in);
  end

  // Decoder: classify by overall parity and syndrome, flip the single bad
  // bit when correctable. S=0 with P=1 means the overall parity bit itself.
  always_comb begin
    syn_s    = ecc_syndrome(dec_in);
    par_s    = ^dec_in;
    fixed_s  = dec_in;
    corr_s   = 1'b0;
    uncorr_s = 1'b0;
    loc_s    = 4'd0;
    case ({par_s, (syn_s != 4'd0)})
      2'b00: begin
        corr_s   = 1'b0;
        uncorr_s = 1'b0;
      end
      2'b01: begin
        uncorr_s = 1'b1;
      end
      2'b10, 2'b11: begin
        corr_s         = 1'b1;
        loc_s          = syn_s;
        fixed_s[syn_s] = ~dec_in[syn_s];
      end
      default: begin
        corr_s   = 1'b0;
        uncorr_s = 1'b0;
      end
    endcase
  end

  assign enc_out       = enc_code_s;
  assign dec_out       = ecc_extract(fixed_s);
  assign err_correct   = corr_s;
  assign err_uncorrect = uncorr_s;
  assign err_location  = loc_s;

  // Reset synchronizer: assert immediately, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign cnt_rst_n_s = rst_sync_r[1];

  ecc_11to16_cnt #(.CNT_W(CNT_W)) u_corr_cnt (
    .clk   (clk),
    .rst_n (cnt_rst_n_s),
    .clr   (cnt_clr),
    .inc   (corr_s),
    .cnt   (corr_cnt)
  );

  ecc_11to16_cnt #(.CNT_W(CNT_W)) u_uncorr_cnt (
    .clk   (clk),
    .rst_n (cnt_rst_n_s),
    .clr   (cnt_clr),
    .inc   (uncorr_s),
    .cnt   (uncorr_cnt)
  );

endmodule

// File: tb/tb_ecc_11to16_core.sv
// Scoreboard bench for ecc_11to16_core: the driver pushes expected results,
// a negedge monitor pops and compares them. Counters use a narrow width so
// saturation is reachable quickly.
module tb_ecc_11to16_core;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [10:0]   enc_in = 11'h000;
  logic [15:0]   dec_in = 16'h0000;
  logic [15:0]   enc_out;
  logic [10:0]   dec_out;
  logic          err_correct;
  logic          err_uncorrect;
  logic [3:0]    err_location;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  ecc_11to16_core #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enc_in        (enc_in),
    .enc_out       (enc_out),
    .dec_in        (dec_in),
    .dec_out       (dec_out),
    .err_correct   (err_correct),
    .err_uncorrect (err_uncorrect),
    .err_location  (err_location),
    .cnt_clr       (cnt_clr),
    .corr_cnt      (corr_cnt),
    .uncorr_cnt    (uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          chk_enc;
    logic          chk_dec;
    logic          chk_cnt;
    logic [15:0]   enc_exp;
    logic [10:0]   dout_exp;
    logic          corr_exp;
    logic          unc_exp;
    logic [3:0]    loc_exp;
    logic [CW-1:0] cc_exp;
    logic [CW-1:0] uc_exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic tb_vld = 1'b0;
  logic tb_done = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pos_tab [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Reference encoder written straight from the layout rules.
  function automatic logic [15:0] model_enc(input logic [10:0] d);
    logic [15:0] c;
    logic p;
    c = 16'h0000;
    for (int i = 0; i < 11; i++) c[pos_tab[i]] = d[i];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < 16; i++)
        if (((i >> k) & 1) == 1 && i != (1 << k)) p = p ^ c[i];
      c[1 << k] = p;
    end
    p = 1'b0;
    for (int i = 1; i < 16; i++) p = p ^ c[i];
    c[0] = p;
    return c;
  endfunction

  function automatic logic [10:0] model_ext(input logic [15:0] c);
    logic [10:0] d;
    d = 11'h000;
    for (int i = 0; i < 11; i++) d[i] = c[pos_tab[i]];
    return d;
  endfunction

  function automatic exp_t blank();
    exp_t x;
    x.chk_enc = 1'b0; x.chk_dec = 1'b0; x.chk_cnt = 1'b0;
    x.enc_exp = 16'h0000; x.dout_exp = 11'h000;
    x.corr_exp = 1'b0; x.unc_exp = 1'b0; x.loc_exp = 4'd0;
    x.cc_exp = '0; x.uc_exp = '0;
    return x;
  endfunction

  task automatic push_enc(input logic [10:0] e, input logic [15:0] exp_code);
    exp_t x;
    x = blank();
    enc_in = e;
    x.chk_enc = 1'b1;
    x.enc_exp = exp_code;
    sb_q.push_back(x);
  endtask

  task automatic push_dec(input logic [15:0] d, input logic [10:0] dout,
                          input logic c, input logic u, input logic [3:0] loc);
    exp_t x;
    x = blank();
    dec_in = d;
    x.chk_dec = 1'b1;
    x.dout_exp = dout;
    x.corr_exp = c;
    x.unc_exp = u;
    x.loc_exp = loc;
    sb_q.push_back(x);
  endtask

  // Present the pushed vectors for one cycle; monitor samples at negedge.
  task automatic step();
    tb_vld = 1'b1;
    @(posedge clk);
    #1;
    tb_vld = 1'b0;
  endtask

  task automatic check_cnt(input logic [CW-1:0] cc, input logic [CW-1:0] uc);
    exp_t x;
    x = blank();
    x.chk_cnt = 1'b1;
    x.cc_exp = cc;
    x.uc_exp = uc;
    sb_q.push_back(x);
    step();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: drain every expectation pushed for the current cycle.
  always @(negedge clk) begin
    if (tb_vld) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: actual=0 entries required>=1");
      end
      while (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        if (cur.chk_enc) cmp("enc_out", 32'(enc_out), 32'(cur.enc_exp));
        if (cur.chk_dec) begin
          cmp("dec_out", 32'(dec_out), 32'(cur.dout_exp));
          cmp("err_correct", 32'(err_correct), 32'(cur.corr_exp));
          cmp("err_uncorrect", 32'(err_uncorrect), 32'(cur.unc_exp));
          cmp("err_location", 32'(err_location), 32'(cur.loc_exp));
        end
        if (cur.chk_cnt) begin
          cmp("corr_cnt", 32'(corr_cnt), 32'(cur.cc_exp));
          cmp("uncorr_cnt", 32'(uncorr_cnt), 32'(cur.uc_exp));
        end
      end
    end
    if (tb_done) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int          nf;
    int          b1;
    int          b2;
    logic [10:0] d;
    logic [15:0] cw;
    logic [15:0] bad;

    #1;
    check_cnt(0, 0);
    rst_n = 1'b1;
    cycles(3);

    // Directed encoder vectors
    push_enc(11'h000, 16'h0000); step();
    push_enc(11'h7FF, 16'hFFFF); step();
    push_enc(11'h001, 16'h000F); step();
    push_enc(11'h400, 16'h8117); step();

    // Directed decoder vectors
    push_dec(16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);  step();
    push_dec(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);  step();
    push_dec(16'hFFBF, 11'h7FF, 1'b1, 1'b0, 4'd6);  step();
    push_dec(16'hFFFE, 11'h7FF, 1'b1, 1'b0, 4'd0);  step();
    push_dec(16'hFFBE, 11'h7FB, 1'b0, 1'b1, 4'd0);  step();
    push_dec(16'hFFFD, 11'h7FF, 1'b1, 1'b0, 4'd1);  step();
    push_dec(16'h7FFF, 11'h7FF, 1'b1, 1'b0, 4'd15); step();

    // Random encode + 0/1/2-bit corruption
    for (int n = 0; n < 5000; n++) begin
      d   = 11'($urandom);
      cw  = model_enc(d);
      nf  = $urandom_range(0, 2);
      b1  = $urandom_range(0, 15);
      b2  = (b1 + $urandom_range(1, 15)) % 16;
      bad = cw;
      push_enc(d, cw);
      case (nf)
        0: push_dec(bad, d, 1'b0, 1'b0, 4'd0);
        1: begin
          bad[b1] = ~bad[b1];
          push_dec(bad, d, 1'b1, 1'b0, 4'(b1));
        end
        default: begin
          bad[b1] = ~bad[b1];
          bad[b2] = ~bad[b2];
          push_dec(bad, model_ext(bad), 1'b0, 1'b1, 4'd0);
        end
      endcase
      step();
    end

    // Counters
    dec_in = 16'h0000;
    cnt_clr = 1'b1; cycles(1); cnt_clr = 1'b0;
    check_cnt(0, 0);
    dec_in = 16'hFFBF; cycles(3); dec_in = 16'h0000;
    check_cnt(3, 0);
    dec_in = 16'hFFBE; cycles(2); dec_in = 16'h0000;
    check_cnt(3, 2);
    dec_in = 16'hFFBF; cnt_clr = 1'b1; cycles(1); cnt_clr = 1'b0; dec_in = 16'h0000;
    check_cnt(0, 0);
    dec_in = 16'hFFBF; cycles(2); dec_in = 16'h0000;
    check_cnt(2, 0);
    rst_n = 1'b0;
    check_cnt(0, 0);
    dec_in = 16'hFFBF; cycles(2);
    check_cnt(0, 0);
    dec_in = 16'h0000; rst_n = 1'b1; cycles(4);
    check_cnt(0, 0);
    dec_in = 16'hFFBF; cycles(20); dec_in = 16'h0000;
    check_cnt(15, 0);

    tb_done = 1'b1;
  end

endmodule
